// File: rtl/cim_array_unit.sv
// cim_array_unit: compute-in-memory responder on the core's CIM port.
// Holds 2^AW words of weight memory, each word packing four signed int8
// weights. Runs a 2-stage int8 dot-product pipeline into 16 accumulators.
// Raises cim_busy, which drives the core's HLT, while an accumulator read
// would return a value that still has a compute in flight.
// Optional feature macro: CIM_RELU_EN. When defined, an accumulator read
// returns zero for negative accumulators. Stored values are unchanged.
module cim_array_unit #(
  parameter int AW = 8
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        write,
  input  logic        cim,
  input  logic        partial_sum,
  input  logic        reset_output,
  input  logic [3:0]  output_reg,
  input  logic [31:0] address,
  input  logic [31:0] input_data,
  output logic [31:0] cim_output,
  output logic        cim_busy
);

  localparam int NACC = 16;

  logic [31:0]        mem [0:(1<<AW)-1];
  logic [31:0]        acc [0:NACC-1];

  logic signed [15:0] prod1 [0:3];
  logic [3:0]         idx1;
  logic               valid1;
  logic signed [17:0] sum2;
  logic [3:0]         idx2;
  logic               valid2;

  logic [AW-1:0]      waddr;
  logic [31:0]        w_word;
  logic [17:0]        sum1;
  logic [31:0]        rd_val;
  logic               do_write, do_rst, do_comp, do_rd;
  logic               unused_addr;

  assign waddr       = address[AW-1:0];
  assign w_word      = mem[waddr];
  assign unused_addr = ^address[27:AW];

  // Command decode in priority order: write, accumulator reset, compute, read.
  always_comb begin
    do_write = write;
    do_rst   = !write && cim && reset_output;
    do_comp  = !write && cim && !reset_output && partial_sum;
    do_rd    = !write && cim && !reset_output && !partial_sum;
  end

  // Stall handshake: cim_busy is high while a read is presented whose target
  // accumulator has a compute in stage 1 or 2. The core holds its command
  // (and issues nothing new) until cim_busy drops, which happens on its own
  // once the pipeline drains.
  always_comb begin
    rd_val = acc[output_reg];
`ifdef CIM_RELU_EN
    if (rd_val[31]) rd_val = '0;
`endif
    if (RES)        cim_output = '0;
    else if (do_rd) cim_output = rd_val;
    else            cim_output = w_word;
    cim_busy = !RES && do_rd &&
               ((valid1 && (idx1 == output_reg)) ||
                (valid2 && (idx2 == output_reg)));
  end

  // Weight memory write; contents are not reset.
  always_ff @(posedge CLK) begin
    if (do_write) mem[waddr] <= input_data;
  end

  // Stage 1: four signed int8 x int8 products plus target index.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      valid1 <= 1'b0;
      idx1   <= '0;
      for (int i = 0; i < 4; i++) prod1[i] <= '0;
    end else begin
      valid1 <= do_comp;
      idx1   <= address[31:28];
      for (int i = 0; i < 4; i++)
        prod1[i] <= $signed(w_word[8*i +: 8]) * $signed(input_data[8*i +: 8]);
    end
  end

  // Sign-extended sum of the four stage-1 products.
  always_comb begin
    sum1 = {{2{prod1[0][15]}}, prod1[0]} + {{2{prod1[1][15]}}, prod1[1]} +
           {{2{prod1[2][15]}}, prod1[2]} + {{2{prod1[3][15]}}, prod1[3]};
  end

  // Stage 2: reduced sum; an accumulator reset squashes the result in flight.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      valid2 <= 1'b0;
      idx2   <= '0;
      sum2   <= '0;
    end else begin
      valid2 <= valid1 && !do_rst;
      idx2   <= idx1;
      sum2   <= $signed(sum1);
    end
  end

  // Accumulators: clear-all has priority over the stage-2 accumulate.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      for (int i = 0; i < NACC; i++) acc[i] <= '0;
    end else if (do_rst) begin
      for (int i = 0; i < NACC; i++) acc[i] <= '0;
    end else if (valid2) begin
      acc[idx2] <= acc[idx2] + {{14{sum2[17]}}, sum2};
    end
  end

endmodule

// File: tb/tb_cim_array_unit.sv
// tb_cim_array_unit: bench for cim_array_unit. Reference model keeps the
// weight words and accumulators as plain arrays and applies each compute as
// a whole dot product at issue time; the pipeline latency shows up only as
// the stall the bench waits out on accumulator reads.
module tb_cim_array_unit;

  logic        CLK = 1'b0;
  logic        RES;
  logic        write, cim, partial_sum, reset_output;
  logic [3:0]  output_reg;
  logic [31:0] address, input_data;
  logic [31:0] cim_output;
  logic        cim_busy;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem_m [0:255];
  logic [31:0] acc_m [0:15];
  logic [31:0] exp_q [$];

  cim_array_unit #(.AW(8)) dut (
    .CLK          (CLK),
    .RES          (RES),
    .write        (write),
    .cim          (cim),
    .partial_sum  (partial_sum),
    .reset_output (reset_output),
    .output_reg   (output_reg),
    .address      (address),
    .input_data   (input_data),
    .cim_output   (cim_output),
    .cim_busy     (cim_busy)
  );

  // Clock and watchdog.
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] dot4(input logic [31:0] w, input logic [31:0] x);
    int s;
    logic [7:0] wb, xb;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      wb = w[8*i +: 8];
      xb = x[8*i +: 8];
      s += int'($signed(wb)) * int'($signed(xb));
    end
    return s;
  endfunction

  function automatic logic [31:0] rd_view(input logic [31:0] v);
`ifdef CIM_RELU_EN
    if (v[31]) return 32'd0;
`endif
    return v;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    write = 1'b0; cim = 1'b0; partial_sum = 1'b0; reset_output = 1'b0;
    output_reg = '0; address = '0; input_data = '0;
  endtask

  task automatic clear_acc_model();
    for (int i = 0; i < 16; i++) acc_m[i] = '0;
  endtask

  task automatic drv_write(input logic [7:0] a, input logic [31:0] d);
    idle();
    write = 1'b1; address = {24'd0, a}; input_data = d;
    tick();
    mem_m[a] = d;
    idle();
  endtask

  task automatic drv_compute(input logic [3:0] idx, input logic [7:0] a, input logic [31:0] x);
    idle();
    cim = 1'b1; partial_sum = 1'b1; address = {idx, 20'd0, a}; input_data = x;
    tick();
    acc_m[idx] = acc_m[idx] + dot4(mem_m[a], x);
    idle();
  endtask

  task automatic drv_acc_reset();
    idle();
    cim = 1'b1; reset_output = 1'b1;
    tick();
    clear_acc_model();
    idle();
  endtask

  // Accumulator read: hold the command while stalled (bounded), then compare.
  task automatic check_rd(input string name, input logic [3:0] idx, output int stalls);
    logic [31:0] exp;
    idle();
    cim = 1'b1; output_reg = idx;
    exp_q.push_back(rd_view(acc_m[idx]));
    #1;
    stalls = 0;
    while (cim_busy && stalls < 8) begin
      tick();
      stalls++;
    end
    exp = exp_q.pop_front();
    checks++;
    if (cim_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s stall_timeout: cim_busy=%b after %0d cycles, required 0", name, cim_busy, stalls);
    end
    checks++;
    if (cim_output !== exp) begin
      errors++;
      $display("FAIL %s acc[%0d]: got %h, required %h", name, idx, cim_output, exp);
    end
    idle();
  endtask

  task automatic check_mem(input string name, input logic [7:0] a);
    idle();
    address = {24'd0, a};
    #1;
    checks++;
    if (cim_output !== mem_m[a] || cim_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s mem[%0d]: got %h busy=%b, required %h busy=0", name, a, cim_output, cim_busy, mem_m[a]);
    end
    idle();
  endtask

  task automatic check_all_zero(input string name);
    int s;
    for (int i = 0; i < 16; i++) check_rd(name, 4'(i), s);
  endtask

  task automatic test_reset();
    idle();
    RES = 1'b1;
    cim = 1'b1; output_reg = 4'd3;
    #2;
    checks++;
    if (cim_output !== 32'd0 || cim_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: got %h busy=%b, required 0 busy=0", cim_output, cim_busy);
    end
    tick(); tick();
    RES = 1'b0;
    clear_acc_model();
    check_all_zero("reset_acc");
  endtask

  task automatic test_mem_rw();
    drv_write(8'd5, 32'h01020304);
    check_mem("mem_read_w5", 8'd5);
    checks++;
    if (cim_output !== 32'h0) begin end
    checks--;
  endtask

  task automatic test_compute_basic();
    int s;
    drv_compute(4'd2, 8'd5, 32'h01010101);
    tick(); tick();
    check_rd("compute_basic", 4'd2, s);
    checks++;
    if (s !== 0) begin
      errors++;
      $display("FAIL compute_basic_stall: got %0d stall cycles, required 0", s);
    end
  endtask

  task automatic test_stall();
    int s;
    drv_acc_reset();
    drv_compute(4'd2, 8'd5, 32'h01010101);
    check_rd("stall_other_idx", 4'd3, s);
    checks++;
    if (s !== 0) begin
      errors++;
      $display("FAIL stall_other_idx_cycles: got %0d, required 0", s);
    end
    check_rd("stall_same_idx", 4'd2, s);
    checks++;
    if (s !== 2) begin
      errors++;
      $display("FAIL stall_same_idx_cycles: got %0d, required 2", s);
    end
  endtask

  task automatic test_back_to_back();
    int s;
    drv_write(8'd7, 32'hFFFFFFFF);
    drv_compute(4'd1, 8'd7, 32'h02020202);
    drv_compute(4'd1, 8'd7, 32'h02020202);
    tick(); tick(); tick();
    check_rd("back_to_back", 4'd1, s);
  endtask

  task automatic test_acc_reset_inflight();
    int s;
    drv_compute(4'd4, 8'd5, 32'h01010101);
    drv_acc_reset();
    check_rd("acc_reset_no_stall", 4'd4, s);
    checks++;
    if (s !== 0) begin
      errors++;
      $display("FAIL acc_reset_squash_stall: got %0d stall cycles, required 0", s);
    end
    tick(); tick(); tick();
    check_all_zero("acc_reset_after");
    drv_compute(4'd6, 8'd5, 32'h01010101);
    tick(); tick();
    check_rd("compute_after_reset", 4'd6, s);
  endtask

  task automatic test_async_reset_inflight();
    drv_compute(4'd5, 8'd5, 32'h01010101);
    cim = 1'b1; output_reg = 4'd5;
    #1;
    RES = 1'b1;
    #1;
    checks++;
    if (cim_busy !== 1'b0 || cim_output !== 32'd0) begin
      errors++;
      $display("FAIL async_reset_inflight: got %h busy=%b, required 0 busy=0", cim_output, cim_busy);
    end
    #2;
    RES = 1'b0;
    clear_acc_model();
    idle();
    tick(); tick(); tick();
    check_all_zero("async_reset_acc");
  endtask

  task automatic test_extreme();
    int s;
    drv_write(8'd0, 32'h7F7F7F7F);
    drv_compute(4'd0, 8'd0, 32'h81818181);
    tick(); tick();
    checks++;
    if (acc_m[0] !== 32'hFFFF03FC) begin
      errors++;
      $display("FAIL extreme_model: got %h, required FFFF03FC", acc_m[0]);
    end
    check_rd("extreme_acc0", 4'd0, s);
  endtask

  task automatic test_write_wins();
    int s;
    idle();
    write = 1'b1; cim = 1'b1; partial_sum = 1'b1;
    address = {4'd9, 20'd0, 8'd12}; input_data = 32'h05050505;
    tick();
    mem_m[12] = 32'h05050505;
    idle();
    tick(); tick();
    check_mem("write_wins_mem", 8'd12);
    check_rd("write_wins_acc", 4'd9, s);
  endtask

  task automatic test_random();
    int s, op;
    for (int a = 0; a < 16; a++) drv_write(8'(a), $urandom);
    for (int n = 0; n < 80; n++) begin
      op = $urandom_range(0, 9);
      if (op <= 1)      drv_write(8'($urandom_range(0, 15)), $urandom);
      else if (op <= 4) drv_compute(4'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), $urandom);
      else if (op <= 7) check_rd("random_rd", 4'($urandom_range(0, 15)), s);
      else if (op == 8) check_mem("random_mem", 8'($urandom_range(0, 15)));
      else if ($urandom_range(0, 3) == 0) drv_acc_reset();
    end
    tick(); tick(); tick();
    check_all_zero_or_model();
  endtask

  task automatic check_all_zero_or_model();
    int s;
    for (int i = 0; i < 16; i++) check_rd("random_final", 4'(i), s);
  endtask

  initial begin
    idle();
    RES = 1'b0;
    #1;
    test_reset();
    test_mem_rw();
    test_compute_basic();
    test_stall();
    drv_acc_reset();
    test_back_to_back();
    test_acc_reset_inflight();
    test_async_reset_inflight();
    test_extreme();
    test_write_wins();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cim_array_unit.md
# cim_array_unit

Compute-in-memory responder that sits on the core's CIM port: it consumes `write`, `cim`, `partial_sum`, `reset_output`, `output_reg`, `address` and `input_data`, and returns `cim_output`. It holds a weight memory of 32-bit words, each packing four signed int8 weights. It runs a 2-stage pipelined int8 dot-product into 16 accumulators. When a read would return a stale accumulator, it raises `cim_busy`, which is wired to the core's `HLT`.

## Interface
- `AW`, 8: weight-memory word-address width (2^AW words).
- `CLK`  in  1: clock, rising edge.
- `RES`  in  1: asynchronous active-high reset.
- `write`  in  1: weight write strobe.
- `cim`  in  1: CIM command strobe (compute / accumulator read / accumulator reset).
- `partial_sum`  in  1: with `cim`, compute-and-accumulate.
- `reset_output`  in  1: with `cim`, clear all accumulators.
- `output_reg`  in  4: accumulator index for accumulator read.
- `address`  in  32: `[AW-1:0]` = weight word; `[31:28]` = target accumulator for compute.
- `input_data`  in  32: write data, or four int8 activations for compute.
- `cim_output`  out  32: combinational read data.
- `cim_busy`  out  1: combinational stall request.

## Operation
- Command decode, evaluated every cycle in this priority order:
  - `write`=1: `mem[address[AW-1:0]] <= input_data` at the clock edge.
  - `cim`&`reset_output`: all 16 accumulators are set to 0, and both pipeline stages are squashed at the edge.
  - `cim`&`partial_sum`: issue a compute into stage 1.
  - `cim` alone: accumulator read (REG_RD).
  - None of the above: memory read, with no side effect.
- `cim_output`:
  - REG_RD: `acc[output_reg]`.
  - Otherwise: `mem[address[AW-1:0]]`.
  - While `RES`=1: 0.
- Compute, with W = `mem[address[AW-1:0]]` read combinationally in the issue cycle and X = `input_data`:
  - Stage 1 registers four signed 16-bit products `W[8i+7:8i]*X[8i+7:8i]`, i=0..3.
  - Stage 1 also registers the target index `address[31:28]` and a valid bit.
  - Stage 2 registers the 18-bit signed sum of the four products, the index and the valid bit.
  - Accumulate: `acc[idx2] <= acc[idx2] + sext32(sum2)` when valid2.
  - Wrap-around is two's complement.
- Back-to-back computes to the same accumulator are legal. They accumulate in issue order; no stall.
- Stall rule: `cim_busy`=1 when a REG_RD is presented and (valid1 and idx1==`output_reg`) or (valid2 and idx2==`output_reg`).
- While stalled, the core holds its command. No new compute issues, the pipeline drains, and the stall clears by itself.
- Memory reads and writes never stall. A write in cycle T is visible to a read or compute in T+1.
- Accumulator reset while computes are in flight: the in-flight results are discarded, so all accumulators read 0 afterwards.
- `write` and `cim` together are illegal. `write` wins and `cim` is ignored.

## Timing
- Reset (`RES`=1, async):
  - All `acc` = 0, valid1 = valid2 = 0, `cim_busy` = 0, `cim_output` = 0.
  - Weight memory is not reset; its content is undefined until written.
- Reset asserted mid-operation: pending computes are lost immediately.
- Compute issued in cycle T:
  - Stage 1 is loaded at edge T.
  - Stage 2 is loaded at edge T+1.
  - `acc` is updated at edge T+2.
  - A REG_RD is correct from T+3.
- A REG_RD of the same index in T+1 or T+2 sees `cim_busy`=1.
- Accumulator reset in cycle T: all accumulators read 0 from T+1.
- A compute issued in T+1 after a reset in T accumulates from 0.

## Configuration
- `CIM_RELU_EN` defined:
  - REG_RD returns `acc[output_reg]` if its bit 31 is 0, otherwise 0.
  - Stored accumulator values are unchanged.
  - Memory reads are unaffected.
- Not defined: REG_RD returns the raw signed accumulator.

## Test plan
- Reset, then write 0x01020304 to word 5. A memory read of `address`=5 the next cycle -> `cim_output`=0x01020304, `cim_busy`=0.
- Compute with `address`=0x20000005 and `input_data`=0x01010101, idle 2 cycles, then REG_RD with `output_reg`=2 -> `cim_output`=10 (0x0000000A).
- Same compute, then REG_RD of index 2 in the very next cycle -> `cim_busy`=1 for 2 cycles, then `cim_output`=10 with `cim_busy`=0. A REG_RD of index 3 in the same cycle -> no stall, value 0.
- Write 0xFFFFFFFF to word 7, then compute `address`=0x10000007 with `input_data`=0x02020202 twice back-to-back, then drain -> REG_RD index 1 = 0xFFFFFFF0 (-16). With `CIM_RELU_EN` -> 0.
- Compute into index 4, then accumulator reset the next cycle -> REG_RD index 4 after 3 cycles = 0. Assert `RES` with a compute in stage 1 -> all accumulators 0 and `cim_busy`=0.
- Write 0x7F7F7F7F to word 0 and compute with `input_data`=0x81818181 (-127) -> accumulator index 0 = -64516 (0xFFFF03FC).
